// File: rtl/systolic_sched_pkg.sv
// Shared types and constants for the systolic tile scheduler.
//   sched_state_t   : scheduler FSM states
//   MODE_*          : job mode encodings, also used by the memory controller
//   CNT_*           : indices of the phase counters inside the scheduler
//   mode_to_sel()   : job mode -> {systolic_mode, transpose_sel}
//   mode_is_legal() : true for the four defined job modes
package systolic_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COMP  = 3'd2,
    S_FILL  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } sched_state_t;

  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_AS   = 3'd1;
  localparam logic [2:0] MODE_SA   = 3'd2;
  localparam logic [2:0] MODE_SB   = 3'd3;
  localparam logic [2:0] MODE_BS   = 3'd4;

  // Phase counter slots: beat counter serves both LOAD and DRAIN.
  localparam int CNT_BEAT = 0;
  localparam int CNT_K    = 1;
  localparam int CNT_FILL = 2;
  localparam int NUM_CNT  = 3;

  // AS/SA are output-stationary, AS/SB use the transposer.
  // Anything else (including MODE_IDLE) decodes to 2'b00.
  function automatic logic [1:0] mode_to_sel(input logic [2:0] mode);
    logic [1:0] sel;
    case (mode)
      MODE_AS: sel = 2'b11;
      MODE_SA: sel = 2'b10;
      MODE_SB: sel = 2'b01;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode >= MODE_AS) && (mode <= MODE_BS);
  endfunction

endpackage

// File: rtl/sched_phase_cnt.sv
// Loadable down-counter used to time one scheduler phase.
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_en)
//   i_load_val  : phase length in beats/cycles
//   i_en        : consume one beat; saturates at zero
//   o_last      : the beat consumed now is the final one of the phase
module sched_phase_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_last
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_last = (r_count == WIDTH'(1));

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile scheduler for the 4x4 systolic multiplier. For every output tile it
// runs LOAD (W operand beats), COMP (k_len beats), FILL (2W-1 pipeline
// flush cycles) and DRAIN (W sum beats), then finishes the job in DONE.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   start, job_mode, tile_count,
//   k_len                          : job request, sampled only in IDLE
//   busy, done, err                : job status (registered)
//   fetch_req, fetch_vld           : operand fetch handshake
//   array_en                       : array/transposer advance enable
//   systolic_state, systolic_mode,
//   transpose_sel                  : datapath controls (registered)
//   sum_valid, sum_ready           : partial-sum handshake to accumulator
//   tile_idx                       : current tile, 0-based
// Optional build macro SYSTOLIC_SCHED_PERF_EN adds stall_cycles and
// job_cycles performance counters.
module systolic_tile_sched
  import systolic_sched_pkg::*;
#(
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           job_mode,
  input  logic [CNT_WIDTH-1:0] tile_count,
  input  logic [CNT_WIDTH-1:0] k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 fetch_req,
  input  logic                 fetch_vld,
  output logic                 array_en,
  output logic                 systolic_state,
  output logic                 systolic_mode,
  output logic                 transpose_sel,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [CNT_WIDTH-1:0] tile_idx
`ifdef SYSTOLIC_SCHED_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          job_cycles
`endif
);

  sched_state_t r_state, w_state_next;

  logic [2:0]           r_job_mode;
  logic [CNT_WIDTH-1:0] r_tile_count;
  logic [CNT_WIDTH-1:0] r_k_len;
  logic [CNT_WIDTH-1:0] r_tile_idx;
  logic                 r_busy, r_done, r_err;
  logic                 r_sys_state, r_sys_mode, r_tsel;

  logic w_accept, w_reject, w_tile_inc;
  logic w_fetch_req, w_array_en, w_sum_valid;

  logic [NUM_CNT-1:0]   w_cnt_load, w_cnt_en, w_cnt_last;
  logic [CNT_WIDTH-1:0] w_cnt_val [NUM_CNT];

  assign w_cnt_val[CNT_BEAT] = CNT_WIDTH'(SYSTOLIC_WIDTH);
  assign w_cnt_val[CNT_K]    = r_k_len;
  assign w_cnt_val[CNT_FILL] = CNT_WIDTH'(2 * SYSTOLIC_WIDTH - 1);

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      sched_phase_cnt #(.WIDTH(CNT_WIDTH)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load[gi]),
        .i_load_val (w_cnt_val[gi]),
        .i_en       (w_cnt_en[gi]),
        .o_last     (w_cnt_last[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Each phase counter is loaded on the transition into its phase, so it
  // always holds the remaining beats of the phase currently running.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_tile_inc   = 1'b0;
    w_cnt_load   = '0;
    w_cnt_en     = '0;
    w_fetch_req  = 1'b0;
    w_array_en   = 1'b0;
    w_sum_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (mode_is_legal(job_mode) && (tile_count != '0) && (k_len != '0)) begin
            w_accept             = 1'b1;
            w_state_next         = S_LOAD;
            w_cnt_load[CNT_BEAT] = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_fetch_req        = 1'b1;
        w_array_en         = fetch_vld;
        w_cnt_en[CNT_BEAT] = fetch_vld;
        if (fetch_vld && w_cnt_last[CNT_BEAT]) begin
          w_state_next      = S_COMP;
          w_cnt_load[CNT_K] = 1'b1;
        end
      end
      S_COMP: begin
        w_fetch_req     = 1'b1;
        w_array_en      = fetch_vld;
        w_cnt_en[CNT_K] = fetch_vld;
        if (fetch_vld && w_cnt_last[CNT_K]) begin
          w_state_next         = S_FILL;
          w_cnt_load[CNT_FILL] = 1'b1;
        end
      end
      S_FILL: begin
        w_array_en         = 1'b1;
        w_cnt_en[CNT_FILL] = 1'b1;
        if (w_cnt_last[CNT_FILL]) begin
          w_state_next         = S_DRAIN;
          w_cnt_load[CNT_BEAT] = 1'b1;
        end
      end
      S_DRAIN: begin
        w_sum_valid        = 1'b1;
        w_array_en         = sum_ready;
        w_cnt_en[CNT_BEAT] = sum_ready;
        if (sum_ready && w_cnt_last[CNT_BEAT]) begin
          if (r_tile_idx == (r_tile_count - CNT_WIDTH'(1))) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next         = S_LOAD;
            w_cnt_load[CNT_BEAT] = 1'b1;
            w_tile_inc           = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_mode   <= MODE_IDLE;
      r_tile_count <= '0;
      r_k_len      <= '0;
      r_tile_idx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_sys_state  <= 1'b0;
      r_sys_mode   <= 1'b0;
      r_tsel       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_job_mode   <= job_mode;
        r_tile_count <= tile_count;
        r_k_len      <= k_len;
      end
      // Bypass the latch on the accept edge so the mode controls are
      // already valid in the first LOAD cycle.
      {r_sys_mode, r_tsel} <= mode_to_sel(w_accept ? job_mode : r_job_mode);
      if (w_tile_inc) begin
        r_tile_idx <= r_tile_idx + CNT_WIDTH'(1);
      end else if (r_state == S_DONE) begin
        r_tile_idx <= '0;
      end
      r_busy      <= w_state_next inside {S_LOAD, S_COMP, S_FILL, S_DRAIN};
      r_done      <= (w_state_next == S_DONE);
      r_err       <= w_reject;
      r_sys_state <= w_state_next inside {S_COMP, S_FILL, S_DRAIN};
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign systolic_state = r_sys_state;
  assign systolic_mode  = r_sys_mode;
  assign transpose_sel  = r_tsel;
  assign tile_idx       = r_tile_idx;
  assign fetch_req      = w_fetch_req;
  assign array_en       = w_array_en;
  assign sum_valid      = w_sum_valid;

`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_job_cycles;
  logic        w_stall;

  assign w_stall = (((r_state == S_LOAD) || (r_state == S_COMP)) && !fetch_vld) ||
                   ((r_state == S_DRAIN) && !sum_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_job_cycles   <= '0;
    end else if (w_accept) begin
      r_stall_cycles <= '0;
      r_job_cycles   <= '0;
    end else begin
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (r_busy) begin
        r_job_cycles <= r_job_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign job_cycles   = r_job_cycles;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
module tb_systolic_tile_sched;

  localparam int W  = 4;
  localparam int KL = 0;
  localparam int KC = 1;
  localparam int KF = 2;
  localparam int KD = 3;

  typedef struct {
    int kind;
    int tile;
    int idx;
  } item_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  job_mode;
  logic [15:0] tile_count;
  logic [15:0] k_len;
  logic        busy, done, err, fetch_req, fetch_vld, array_en;
  logic        systolic_state, systolic_mode, transpose_sel;
  logic        sum_valid, sum_ready;
  logic [15:0] tile_idx;
`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] stall_cycles, job_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] cur_sel;

  systolic_tile_sched #(.SYSTOLIC_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .job_mode       (job_mode),
    .tile_count     (tile_count),
    .k_len          (k_len),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .fetch_req      (fetch_req),
    .fetch_vld      (fetch_vld),
    .array_en       (array_en),
    .systolic_state (systolic_state),
    .systolic_mode  (systolic_mode),
    .transpose_sel  (transpose_sel),
    .sum_valid      (sum_valid),
    .sum_ready      (sum_ready),
    .tile_idx       (tile_idx)
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .job_cycles     (job_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode of the job mode table: {systolic_mode, transpose_sel}.
  function automatic logic [1:0] sel_of(input logic [2:0] m);
    case (m)
      3'd1:    return 2'b11;
      3'd2:    return 2'b10;
      3'd3:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] obs_vec();
    return {7'd0, busy, done, err, fetch_req, array_en, systolic_state,
            systolic_mode, transpose_sel, sum_valid, tile_idx};
  endfunction

  function automatic logic [31:0] exp_vec(input bit b, input bit d, input bit e,
                                          input bit fr, input bit ae, input bit ss,
                                          input logic [1:0] sel, input bit sv, input int tile);
    logic [15:0] t;
    t = tile[15:0];
    return {7'd0, b, d, e, fr, ae, ss, sel, sv, t};
  endfunction

  // Runs one job against a phase-list model: every tile is W load beats,
  // k compute beats, 2W-1 fill cycles and W drain beats; a beat is consumed
  // only when its handshake is met. policy 0: no stalls, 1: random,
  // 2: 3-cycle fetch stall mid-COMP, 3: 5-cycle sum backpressure in DRAIN.
  task automatic run_job(input logic [2:0] mode, input int tiles, input int k,
                         input int policy, input bit busy_start, input bit abort,
                         output int done_cyc, output int n_fetch, output int n_sum,
                         output int n_stall, output int n_aen_off);
    item_t q[$];
    item_t it;
    item_t h;
    int stall_left;
    logic [1:0] sel;
    bit fr, sv, ae, hs;
    sel = sel_of(mode);
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i < W; i++)         begin it.kind = KL; it.tile = t; it.idx = i; q.push_back(it); end
      for (int i = 0; i < k; i++)         begin it.kind = KC; it.tile = t; it.idx = i; q.push_back(it); end
      for (int i = 0; i < 2 * W - 1; i++) begin it.kind = KF; it.tile = t; it.idx = i; q.push_back(it); end
      for (int i = 0; i < W; i++)         begin it.kind = KD; it.tile = t; it.idx = i; q.push_back(it); end
    end
    stall_left = (policy == 2) ? 3 : (policy == 3) ? 5 : 0;
    done_cyc = -1; n_fetch = 0; n_sum = 0; n_stall = 0; n_aen_off = 0;
    start = 1'b1; job_mode = mode; tile_count = tiles[15:0]; k_len = k[15:0];
    @(posedge clk);
    cur_sel = sel;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      start      = 1'b0;
      job_mode   = 3'($urandom_range(0, 7));
      tile_count = 16'($urandom);
      k_len      = 16'($urandom);
      if (q.size() == 0) begin
        fetch_vld = 1'($urandom); sum_ready = 1'($urandom);
        #1;
        check("done_cycle", obs_vec(), exp_vec(0, 1, 0, 0, 0, 0, sel, 0, tiles - 1));
        done_cyc = n;
        break;
      end
      h = q[0];
      fetch_vld = (policy == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      sum_ready = (policy == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (policy == 2 && h.kind == KC && h.tile == 0 && h.idx == 2 && stall_left > 0) begin
        fetch_vld = 1'b0; stall_left--;
      end
      if (policy == 3 && h.kind == KD && h.tile == 0 && h.idx == 1 && stall_left > 0) begin
        sum_ready = 1'b0; stall_left--;
      end
      if (busy_start && h.kind == KD) begin
        start = 1'b1; job_mode = (mode == 3'd1) ? 3'd4 : 3'd1;
      end
      if (abort && h.kind == KC && h.tile == 1 && h.idx == 3) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_idle", obs_vec(), 32'd0);
        rst = 1'b0; fetch_vld = 1'b0; sum_ready = 1'b0;
        cur_sel = 2'b00; done_cyc = 0;
        return;
      end
      #1;
      fr = (h.kind == KL) || (h.kind == KC);
      sv = (h.kind == KD);
      ae = fr ? fetch_vld : (sv ? sum_ready : 1'b1);
      check("cycle", obs_vec(), exp_vec(1, 0, 0, fr, ae, h.kind != KL, sel, sv, h.tile));
      if (fetch_req && fetch_vld) n_fetch++;
      if (sum_valid && sum_ready) n_sum++;
      if (busy && !array_en) n_aen_off++;
      hs = fr ? fetch_vld : (sv ? sum_ready : 1'b1);
      if (!hs) n_stall++;
      if (hs) void'(q.pop_front());
    end
    if (done_cyc < 0) begin
      n_cmp++; n_bad++;
      $error("FAIL job_timeout observed=no_done expected=done");
    end
    @(negedge clk);
    fetch_vld = 1'($urandom); sum_ready = 1'($urandom);
    #1;
    check("idle_after_done", obs_vec(), exp_vec(0, 0, 0, 0, 0, 0, sel, 0, 0));
`ifdef SYSTOLIC_SCHED_PERF_EN
    check("stall_cycles", stall_cycles, n_stall);
    check("job_cycles", job_cycles, done_cyc - 1);
`endif
  endtask

  task automatic illegal_start(input logic [2:0] mode, input int tc, input int k);
    start = 1'b1; job_mode = mode; tile_count = tc[15:0]; k_len = k[15:0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("err_pulse", obs_vec(), exp_vec(0, 0, 1, 0, 0, 0, cur_sel, 0, 0));
    @(negedge clk);
    #1;
    check("err_clear", obs_vec(), exp_vec(0, 0, 0, 0, 0, 0, cur_sel, 0, 0));
  endtask

  initial begin
    int dc, nf, ns, nst, nae;
    int base;
    rst = 1'b1; start = 1'b0; job_mode = 3'd0; tile_count = 16'd0; k_len = 16'd0;
    fetch_vld = 1'b0; sum_ready = 1'b0; cur_sel = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", obs_vec(), 32'd0);
    rst = 1'b0;

    // Nominal: AS, 2 tiles, k=8, no stalls.
    run_job(3'd1, 2, 8, 0, 0, 0, dc, nf, ns, nst, nae);
    $display("job nominal: done_cycle=%0d fetch=%0d sum=%0d", dc, nf, ns);
    check("nominal_done_cycle", dc, 47);
    check("nominal_fetch_beats", nf, 24);
    check("nominal_sum_beats", ns, 8);

    // Fetch stall: BS, 1 tile, k=4, 3 stall cycles mid-COMP.
    run_job(3'd4, 1, 4, 2, 0, 0, dc, nf, ns, nst, nae);
    $display("job fetch_stall: done_cycle=%0d stalls=%0d", dc, nst);
    base = (4 * W - 1 + 4) + 1;
    check("stall_done_delay", dc, base + 3);
    check("stall_array_en_off", nae, 3);

    // Sum backpressure: SA, 1 tile, k=3, 5 cycles sum_ready low.
    run_job(3'd2, 1, 3, 3, 0, 0, dc, nf, ns, nst, nae);
    $display("job backpressure: done_cycle=%0d sum=%0d", dc, ns);
    base = (4 * W - 1 + 3) + 1;
    check("bp_done_delay", dc, base + 5);
    check("bp_sum_beats", ns, 4);
    check("bp_array_en_off", nae, 5);

    // Illegal starts.
    illegal_start(3'd0, 2, 3);
    $display("illegal start mode=0");
    illegal_start(3'd2, 0, 3);
    $display("illegal start tile_count=0");
    illegal_start(3'd3, 2, 0);
    $display("illegal start k_len=0");
    illegal_start(3'd7, 1, 1);
    $display("illegal start mode=7");

    // Reset mid-COMP of tile 1, then immediate re-accept.
    run_job(3'd3, 3, 5, 1, 0, 1, dc, nf, ns, nst, nae);
    $display("job aborted by reset");
    run_job(3'd2, 1, 2, 1, 0, 0, dc, nf, ns, nst, nae);
    $display("job after reset: done_cycle=%0d", dc);
    check("reaccept_fetch_beats", nf, W + 2);

    // Start while busy with another mode during DRAIN.
    run_job(3'd1, 2, 3, 1, 1, 0, dc, nf, ns, nst, nae);
    $display("job start_while_busy: done_cycle=%0d sum=%0d", dc, ns);
    check("busy_start_sum_beats", ns, 2 * W);

    // Random jobs.
    for (int j = 0; j < 5; j++) begin
      logic [2:0] m;
      int t, k;
      m = 3'($urandom_range(1, 4));
      t = $urandom_range(1, 3);
      k = $urandom_range(1, 6);
      run_job(m, t, k, 1, 0, 0, dc, nf, ns, nst, nae);
      $display("job random %0d: mode=%0d tiles=%0d k=%0d done_cycle=%0d stalls=%0d", j, m, t, k, dc, nst);
      check("rand_done_cycle", dc, t * (4 * W - 1 + k) + nst + 1);
      check("rand_fetch_beats", nf, t * (W + k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
